mlp_dp_scheduler: RTL and testbench

MLP_DP_SCHEDULER -- requirements
Module: mlp_dp_scheduler

---
 rtl/mlp_dp_scheduler.sv | 173 +++++++++++++++++
 tb/tb_mlp_dp_scheduler.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_dp_scheduler.sv
// Round-robin burst scheduler feeding an MLP datapath, with result tagging.
// Optional stall abort enabled by defining MLP_DP_SCHED_TIMEOUT_EN.
module mlp_dp_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int RES_WIDTH  = 32,
  parameter int LATENCY    = 6,
  parameter int TIMEOUT    = 15
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_last,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic                          o_dp_valid,
  output logic                          o_dp_first,
  output logic                          o_dp_last,
  output logic [DATA_WIDTH-1:0]         o_dp_data,
  input  logic [RES_WIDTH-1:0]          i_dp_result,
  output logic [NUM_REQ-1:0]            o_res_valid,
  output logic [RES_WIDTH-1:0]          o_res_data,
  output logic                          o_timeout
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = IW + 2;

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state;
  logic [1:0]      rst_sync;
  logic            rst_n;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gnt;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   nxt;
  logic [IW-1:0]   dp_id;
  logic            any;
  logic            first_pend;
  logic            accept;
  logic            expire;
  logic [TW-1:0]   tag_in;
  logic [TW-1:0]   tag_out;
  logic            fire;

  // Assert asynchronously, release two edges later.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) rst_sync <= '0;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_comb begin
    int idx;
    idx  = 0;
    pick = '0;
    any  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any && i_req_valid[idx]) begin
        any  = 1'b1;
        pick = IW'(idx);
      end
    end
  end

  assign nxt    = (gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
  assign accept = (state == BURST) && i_req_valid[gnt];
  assign o_req_ready = (state == BURST) ? (NUM_REQ'(1) << gnt) : '0;

`ifdef MLP_DP_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] stall_cnt;
  logic          stall;
  logic          tout;

  assign stall  = (state == BURST) && !i_req_valid[gnt];
  assign expire = stall && (stall_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      tout      <= 1'b0;
    end else begin
      tout <= expire;
      if (!stall || expire) stall_cnt <= '0;
      else                  stall_cnt <= stall_cnt + 1'b1;
    end
  end
  assign o_timeout = tout;
`else
  assign expire    = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt        <= '0;
      dp_id      <= '0;
      first_pend <= 1'b0;
      o_dp_valid <= 1'b0;
      o_dp_first <= 1'b0;
      o_dp_last  <= 1'b0;
      o_dp_data  <= '0;
    end else begin
      o_dp_valid <= 1'b0;
      o_dp_first <= 1'b0;
      o_dp_last  <= 1'b0;
      o_dp_data  <= '0;
      unique case (state)
        IDLE: begin
          if (any) begin
            gnt        <= pick;
            first_pend <= 1'b1;
            state      <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            o_dp_valid <= 1'b1;
            o_dp_first <= first_pend;
            o_dp_last  <= i_req_last[gnt];
            o_dp_data  <= i_req_data[gnt*DATA_WIDTH +: DATA_WIDTH];
            dp_id      <= gnt;
            first_pend <= 1'b0;
            if (i_req_last[gnt]) begin
              state <= IDLE;
              ptr   <= nxt;
            end
          end else if (expire) begin
            // Forced zero beat closes the accumulation.
            o_dp_valid <= 1'b1;
            o_dp_first <= first_pend;
            o_dp_last  <= 1'b1;
            dp_id      <= gnt;
            first_pend <= 1'b0;
            state      <= IDLE;
            ptr        <= nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tag_in = {o_dp_valid, o_dp_last, dp_id};

  generate
    if (LATENCY == 0) begin : g_direct
      assign tag_out = tag_in;
    end else begin : g_pipe
      logic [TW-1:0] pipe [LATENCY];
      always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= tag_in;
          for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign tag_out = pipe[LATENCY-1];
    end
  endgenerate

  assign fire        = tag_out[TW-1] & tag_out[TW-2];
  assign o_res_valid = fire ? (NUM_REQ'(1) << tag_out[IW-1:0]) : '0;
  assign o_res_data  = fire ? i_dp_result : '0;

endmodule

// File: tb/tb_mlp_dp_scheduler.sv
// Directed bench for mlp_dp_scheduler: arbitration, bursts, tags, reset.
// Define MLP_DP_SCHED_TIMEOUT_EN to exercise the stall abort path.
module tb_mlp_dp_scheduler;

  localparam int N   = 4;
  localparam int DW  = 64;
  localparam int RW  = 32;
  localparam int LAT = 6;
  localparam int TO  = 15;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_data;
  logic            dp_valid;
  logic            dp_first;
  logic            dp_last;
  logic [DW-1:0]   dp_data;
  logic [RW-1:0]   dp_result;
  logic [N-1:0]    res_valid;
  logic [RW-1:0]   res_data;
  logic            timeout;

  always #5 clk = ~clk;

  mlp_dp_scheduler #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .RES_WIDTH(RW),
    .LATENCY(LAT), .TIMEOUT(TO)
  ) dut (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_req_valid(req_valid), .i_req_last(req_last),
    .o_req_ready(req_ready), .i_req_data(req_data),
    .o_dp_valid(dp_valid), .o_dp_first(dp_first),
    .o_dp_last(dp_last), .o_dp_data(dp_data),
    .i_dp_result(dp_result), .o_res_valid(res_valid),
    .o_res_data(res_data), .o_timeout(timeout)
  );

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
    logic          first;
    logic          last;
  } beat_t;

  typedef struct {
    int            cyc;
    logic [N-1:0]  v;
    logic [RW-1:0] d;
  } res_t;

  int    cyc = 0;
  int    checks = 0;
  int    fails = 0;
  beat_t beats[$];
  res_t  ress[$];
  int    tos[$];

  int   left [N];
  int   sent [N];
  int   stall_beat [N];
  int   stall_cnt [N];
  logic [N-1:0] stalled;

  always @(posedge clk) cyc <= cyc + 1;
  assign dp_result = 32'h1234_0000 + 32'(cyc);

  always @(negedge clk) begin
    beat_t b;
    res_t  q;
    if (dp_valid) begin
      b.cyc = cyc; b.data = dp_data;
      b.first = dp_first; b.last = dp_last;
      beats.push_back(b);
    end
    if (res_valid != '0) begin
      q.cyc = cyc; q.v = res_valid; q.d = res_data;
      ress.push_back(q);
    end
    if (timeout) tos.push_back(cyc);
  end

  function automatic logic [DW-1:0] mk(int r, int k);
    return 64'hD000_0000_0000_0000 | (64'(r) << 8) | 64'(k);
  endfunction

  task automatic clear_drv();
    for (int r = 0; r < N; r++) begin
      left[r] = 0; sent[r] = 0;
      stall_beat[r] = -1; stall_cnt[r] = 0;
    end
    stalled   = '0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
  endtask

  task automatic drive();
    for (int r = 0; r < N; r++) begin
      stalled[r] = left[r] > 0 && sent[r] == stall_beat[r]
                   && stall_cnt[r] > 0;
      req_valid[r] = left[r] > 0 && !stalled[r];
      req_last[r]  = left[r] == 1;
      req_data[r*DW +: DW] = mk(r, sent[r]);
    end
  endtask

  task automatic step();
    logic [N-1:0] acc;
    drive();
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int r = 0; r < N; r++) begin
      if (acc[r]) begin
        left[r]--;
        sent[r]++;
      end else if (stalled[r]) begin
        stall_cnt[r]--;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_drv();
    repeat (2) begin @(posedge clk); #1; end
    reset_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    beats.delete(); ress.delete(); tos.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_drv();
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (req_ready !== '0) begin
      fails++; $display("FAIL reset_ready: got %b want 0", req_ready);
    end
    checks++;
    if ({dp_valid, dp_first, dp_last} !== 3'b000) begin
      fails++;
      $display("FAIL reset_dp_flags: got %b want 000",
               {dp_valid, dp_first, dp_last});
    end
    checks++;
    if (dp_data !== '0) begin
      fails++; $display("FAIL reset_dp_data: got %h want 0", dp_data);
    end
    checks++;
    if (res_valid !== '0 || res_data !== '0 || timeout !== 1'b0) begin
      fails++;
      $display("FAIL reset_res: got %b/%h/%b want 0/0/0",
               res_valid, res_data, timeout);
    end
  endtask

  task automatic test_release();
    int seen;
    seen = -1;
    left[2] = 1;
    reset_n = 1'b1;
    step();
    checks++;
    if (req_ready !== '0) begin
      fails++; $display("FAIL release_edge1: got %b want 0000", req_ready);
    end
    step();
    checks++;
    if (req_ready !== '0) begin
      fails++; $display("FAIL release_edge2: got %b want 0000", req_ready);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      if (req_ready[2] && seen < 0) seen = i;
    end
    checks++;
    if (seen < 0) begin
      fails++; $display("FAIL release_grant: got none want grant to 2");
    end
  endtask

  task automatic test_three_beat();
    int start;
    start = cyc;
    left[0] = 3;
    repeat (16) step();
    checks++;
    if (beats.size() != 3) begin
      fails++; $display("FAIL three_count: got %0d want 3", beats.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (beats[k].data !== mk(0, k) || beats[k].first !== (k == 0)
            || beats[k].last !== (k == 2) || beats[k].cyc != start + 2 + k)
        begin
          fails++;
          $display("FAIL three_beat%0d: got %h f%b l%b c%0d want %h f%b l%b c%0d",
                   k, beats[k].data, beats[k].first, beats[k].last,
                   beats[k].cyc, mk(0, k), k == 0, k == 2, start + 2 + k);
        end
      end
    end
    checks++;
    if (ress.size() != 1) begin
      fails++; $display("FAIL three_res_count: got %0d want 1", ress.size());
    end else begin
      checks++;
      if (ress[0].v !== 4'b0001 || ress[0].cyc != start + 4 + LAT
          || ress[0].d !== 32'h1234_0000 + 32'(start + 4 + LAT)) begin
        fails++;
        $display("FAIL three_res: got %b c%0d %h want 0001 c%0d %h",
                 ress[0].v, ress[0].cyc, ress[0].d, start + 4 + LAT,
                 32'h1234_0000 + 32'(start + 4 + LAT));
      end
    end
  endtask

  task automatic test_four_way();
    int start;
    beats.delete(); ress.delete();
    start = cyc;
    for (int r = 0; r < N; r++) left[r] = 1;
    repeat (20) step();
    checks++;
    if (beats.size() != 4 || ress.size() != 4) begin
      fails++;
      $display("FAIL four_count: got %0d/%0d want 4/4",
               beats.size(), ress.size());
    end else begin
      for (int r = 0; r < N; r++) begin
        checks++;
        if (beats[r].data !== mk(r, 0) || beats[r].first !== 1'b1
            || beats[r].last !== 1'b1 || beats[r].cyc != start + 2 + 2*r) begin
          fails++;
          $display("FAIL four_beat%0d: got %h f%b l%b c%0d want %h f1 l1 c%0d",
                   r, beats[r].data, beats[r].first, beats[r].last,
                   beats[r].cyc, mk(r, 0), start + 2 + 2*r);
        end
        checks++;
        if (ress[r].v !== (4'b0001 << r)
            || ress[r].cyc != start + 2 + 2*r + LAT) begin
          fails++;
          $display("FAIL four_res%0d: got %b c%0d want %b c%0d", r,
                   ress[r].v, ress[r].cyc, 4'b0001 << r,
                   start + 2 + 2*r + LAT);
        end
      end
    end
  endtask

  task automatic test_rr_wrap();
    logic [N-1:0] ord [3];
    clear_drv();
    left[1] = 1;
    repeat (12) step();
    beats.delete(); ress.delete();
    clear_drv();
    left[0] = 1; left[1] = 1; left[3] = 1;
    repeat (16) step();
    ord[0] = 4'b1000; ord[1] = 4'b0001; ord[2] = 4'b0010;
    checks++;
    if (beats.size() != 3 || ress.size() != 3) begin
      fails++;
      $display("FAIL rr_count: got %0d/%0d want 3/3",
               beats.size(), ress.size());
    end else begin
      checks++;
      if (beats[0].data !== mk(3, 0) || beats[1].data !== mk(0, 0)
          || beats[2].data !== mk(1, 0)) begin
        fails++;
        $display("FAIL rr_order: got %h %h %h want %h %h %h",
                 beats[0].data, beats[1].data, beats[2].data,
                 mk(3, 0), mk(0, 0), mk(1, 0));
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (ress[k].v !== ord[k]) begin
          fails++;
          $display("FAIL rr_res%0d: got %b want %b", k, ress[k].v, ord[k]);
        end
      end
    end
  endtask

  task automatic test_stall_hold();
    int last2, first1, early;
    last2 = -1; first1 = -1; early = 0;
    beats.delete(); ress.delete();
    clear_drv();
    left[2] = 3; stall_beat[2] = 1; stall_cnt[2] = 4;
    left[1] = 1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (req_ready[1] && left[2] != 0) early++;
      if (left[2] == 0 && last2 < 0) last2 = cyc;
      if (req_ready[1] && first1 < 0) first1 = cyc;
    end
    checks++;
    if (early != 0 || first1 != last2 + 1) begin
      fails++;
      $display("FAIL stall_ready1: got early=%0d first=%0d want 0 %0d",
               early, first1, last2 + 1);
    end
    checks++;
    if (beats.size() != 4 || ress.size() != 2) begin
      fails++;
      $display("FAIL stall_count: got %0d/%0d want 4/2",
               beats.size(), ress.size());
    end else begin
      checks++;
      if (beats[1].cyc - beats[0].cyc != 5
          || beats[2].cyc - beats[1].cyc != 1
          || beats[3].data !== mk(1, 0)) begin
        fails++;
        $display("FAIL stall_gap: got %0d %0d %h want 5 1 %h",
                 beats[1].cyc - beats[0].cyc, beats[2].cyc - beats[1].cyc,
                 beats[3].data, mk(1, 0));
      end
      checks++;
      if (ress[0].v !== 4'b0100 || ress[1].v !== 4'b0010) begin
        fails++;
        $display("FAIL stall_res: got %b %b want 0100 0010",
                 ress[0].v, ress[1].v);
      end
    end
  endtask

  task automatic test_reset_inflight();
    int found;
    found = 0;
    do_reset();
    left[0] = 3;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step();
      if (dp_valid && dp_last) found = 1;
    end
    checks++;
    if (found == 0) begin
      fails++; $display("FAIL inflight_setup: got no last beat want one");
    end
    ress.delete();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({dp_valid, dp_first, dp_last, timeout} !== 4'b0000
        || dp_data !== '0 || req_ready !== '0
        || res_valid !== '0 || res_data !== '0) begin
      fails++;
      $display("FAIL inflight_async: got %b %h %b %b %h want all 0",
               {dp_valid, dp_first, dp_last, timeout}, dp_data,
               req_ready, res_valid, res_data);
    end
    clear_drv();
    repeat (2) step();
    reset_n = 1'b1;
    repeat (LAT + 2) step();
    checks++;
    if (ress.size() != 0) begin
      fails++;
      $display("FAIL inflight_res: got %0d results want 0", ress.size());
    end
  endtask

  task automatic test_timeout();
    beats.delete(); ress.delete(); tos.delete();
    clear_drv();
    left[0] = 3; stall_beat[0] = 1; left[1] = 1;
`ifdef MLP_DP_SCHED_TIMEOUT_EN
    begin
      int to_cyc, first1;
      to_cyc = -1; first1 = -1;
      stall_cnt[0] = TO;
      for (int i = 0; i < 40; i++) begin
        step();
        if (timeout && to_cyc < 0) begin
          to_cyc = cyc;
          left[0] = 0;
        end
        if (req_ready[1] && first1 < 0) first1 = cyc;
      end
      checks++;
      if (tos.size() != 1 || first1 != to_cyc + 1) begin
        fails++;
        $display("FAIL to_pulse: got %0d pulses next=%0d want 1 %0d",
                 tos.size(), first1, to_cyc + 1);
      end
      checks++;
      if (beats.size() != 3 || ress.size() != 2) begin
        fails++;
        $display("FAIL to_count: got %0d/%0d want 3/2",
                 beats.size(), ress.size());
      end else begin
        checks++;
        if (beats[1].data !== '0 || beats[1].last !== 1'b1
            || beats[1].cyc != beats[0].cyc + TO
            || beats[1].cyc != to_cyc) begin
          fails++;
          $display("FAIL to_beat: got %h l%b c%0d want 0 l1 c%0d",
                   beats[1].data, beats[1].last, beats[1].cyc,
                   beats[0].cyc + TO);
        end
        checks++;
        if (ress[0].v !== 4'b0001 || ress[0].cyc != beats[1].cyc + LAT
            || beats[2].data !== mk(1, 0)) begin
          fails++;
          $display("FAIL to_res: got %b c%0d %h want 0001 c%0d %h",
                   ress[0].v, ress[0].cyc, beats[2].data,
                   beats[1].cyc + LAT, mk(1, 0));
        end
      end
    end
`else
    begin
      int bad;
      bad = 0;
      stall_cnt[0] = 40;
      for (int i = 0; i < 42; i++) begin
        step();
        if (req_ready !== 4'b0001 || timeout !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0 || tos.size() != 0 || beats.size() != 1) begin
        fails++;
        $display("FAIL hold_grant: got bad=%0d to=%0d beats=%0d want 0 0 1",
                 bad, tos.size(), beats.size());
      end
      repeat (20) step();
      checks++;
      if (beats.size() != 4 || ress.size() != 2) begin
        fails++;
        $display("FAIL hold_resume: got %0d/%0d want 4/2",
                 beats.size(), ress.size());
      end
    end
`endif
  endtask

  initial begin
    reset_n = 1'b0;
    clear_drv();
    test_reset();
    test_release();
    do_reset();
    test_three_beat();
    do_reset();
    test_four_way();
    test_rr_wrap();
    test_stall_hold();
    test_reset_inflight();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
